td4_reg_demux: RTL and testbench
================================

Name: td4_reg_demux

Overview:
- Write-back side of the TD4 datapath; counterpart of the 4:1 source mux.
- The 4:1 source mux selects one of the registers (A, B, IN, zero) to feed the ALU. This block steers the ALU result back into one of four destination registers: A, B, OUT port or PC.
- It owns those registers, the carry flag and the PC incrementer.
- It sits between the ALU/instruction decoder and the register outputs that feed the source mux and the ROM address.

Parameters:
- WIDTH, 4, data width of registers, ALU result and PC.
- PC_RESET, 0, value PC takes on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- step  input  1  clock enable; when 0 all state holds.
- result  input  WIDTH  ALU sum to be written back.
- carry_in  input  1  ALU carry-out for the current instruction.
- dest_sel  input  2  destination: 0=A, 1=B, 2=OUT, 3=PC.
- dest_en  input  1  write enable for the selected destination.
- reg_a  output  WIDTH  register A.
- reg_b  output  WIDTH  register B.
- out_port  output  WIDTH  output port register.
- pc  output  WIDTH  program counter / ROM address.
- carry_flag  output  1  registered carry (used by JNC).
- out_strobe  output  1  one-cycle pulse after out_port is written.
- load_onehot  output  4  registered one-hot copy of the last committed write (bit n = dest n); 0 if no write.

Behaviour:
- Reset (reset=1 at a rising edge, overrides step and dest_en):
  - reg_a, reg_b, out_port = 0; pc = PC_RESET.
  - carry_flag, out_strobe, load_onehot = 0.
- Reset asserted mid-sequence discards any write presented in that cycle.
- step=0:
  - All registers, pc and carry_flag hold.
  - out_strobe and load_onehot are driven to 0 on that edge (pulses do not stretch).
- step=1, dest_en=1: decode dest_sel to a one-hot write enable. Exactly one destination loads `result` at the edge.
  - dest_sel=0: reg_a <= result.
  - dest_sel=1: reg_b <= result.
  - dest_sel=2: out_port <= result; out_strobe <= 1 for one cycle.
  - dest_sel=3: pc <= result (jump); the incrementer is suppressed this cycle.
  - The other registers hold.
- PC: when step=1 and not loading PC, pc <= pc+1 mod 2^WIDTH (15 -> 0 wraps silently, no flag).
- Carry: when step=1, carry_flag <= carry_in every step, regardless of dest_en.
- step=1, dest_en=0: no register write; pc increments; carry updates; load_onehot <= 0.
- load_onehot <= decoded enable when step=1 and dest_en=1, else 0.
- Latency:
  - Writes are visible on outputs one cycle after the enabling edge.
  - No combinational path from inputs to any output; all outputs are registered.
- Out-of-range values do not exist: dest_sel is fully decoded.
- X on dest_sel while dest_en=0 must not corrupt state.

Test Plan:
- Reset: hold reset=1 with step=1, dest_en=1, dest_sel=0, result=4'hF for 3 cycles -> reg_a=0, pc=0, carry_flag=0, out_strobe=0 throughout.
- Walk destinations: step=1, dest_en=1, dest_sel=0..3 with result=3,5,9,C on successive cycles -> reg_a=3, reg_b=5, out_port=9 with out_strobe high exactly one cycle, pc=C; load_onehot sequence 0001,0010,0100,1000.
- PC increment/wrap: from pc=E, dest_en=0, step=1 for 3 cycles -> pc=F, 0, 1; no other register changes.
- Jump vs increment: pc=4, dest_sel=3, result=2 -> next pc=2 (not 5 or 3); following idle cycle -> pc=3.
- Stall: step=0 for 4 cycles with dest_en=1, dest_sel=1, result=7, carry_in=1 -> reg_b, pc, carry_flag unchanged; out_strobe=0, load_onehot=0.
- Carry tracking and mid-op reset: carry_in=1 with dest_en=0 -> carry_flag=1 next cycle. Then reset=1 on the same edge as dest_sel=2, result=A -> out_port=0, carry_flag=0, out_strobe=0.

Source files
------------

// File: rtl/td4_reg_demux.sv
// TD4 write-back stage: steers the ALU result into A, B, OUT or PC, and owns
// those registers, the carry flag and the PC incrementer.
module td4_reg_demux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PC_RESET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic [1:0]       dest_sel,
  input  logic             dest_en,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             carry_flag,
  output logic             out_strobe,
  output logic [3:0]       load_onehot
);

  localparam int unsigned NUM_DEST = 4;

  logic [NUM_DEST-1:0] write_en_c;

  // Gating by dest_en first keeps an unknown dest_sel from reaching any enable.
  always_comb begin
    write_en_c = '0;
    if (dest_en) begin
      case (dest_sel)
        2'd0:    write_en_c = 4'b0001;
        2'd1:    write_en_c = 4'b0010;
        2'd2:    write_en_c = 4'b0100;
        2'd3:    write_en_c = 4'b1000;
        default: write_en_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_a       <= '0;
      reg_b       <= '0;
      out_port    <= '0;
      pc          <= WIDTH'(PC_RESET);
      carry_flag  <= 1'b0;
      out_strobe  <= 1'b0;
      load_onehot <= '0;
    end else begin
      // Pulses default low so they never stretch across stalled cycles.
      out_strobe  <= 1'b0;
      load_onehot <= '0;
      if (step) begin
        carry_flag  <= carry_in;
        load_onehot <= write_en_c;
        if (write_en_c[0]) reg_a <= result;
        if (write_en_c[1]) reg_b <= result;
        if (write_en_c[2]) begin
          out_port   <= result;
          out_strobe <= 1'b1;
        end
        // A jump replaces the increment rather than adding to it.
        if (write_en_c[3]) pc <= result;
        else               pc <= pc + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_td4_reg_demux.sv
// Directed self-checking bench for td4_reg_demux.
module tb_td4_reg_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] result;
  logic       carry_in;
  logic [1:0] dest_sel;
  logic       dest_en;
  logic [3:0] reg_a, reg_b, out_port, pc;
  logic       carry_flag, out_strobe;
  logic [3:0] load_onehot;

  int checks = 0;
  int errors = 0;

  td4_reg_demux #(.WIDTH(4), .PC_RESET(0)) dut (
    .clk(clk), .reset(reset), .step(step), .result(result),
    .carry_in(carry_in), .dest_sel(dest_sel), .dest_en(dest_en),
    .reg_a(reg_a), .reg_b(reg_b), .out_port(out_port), .pc(pc),
    .carry_flag(carry_flag), .out_strobe(out_strobe), .load_onehot(load_onehot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] o, input logic [3:0] p, input logic c,
                             input logic s, input logic [3:0] l);
    check({tag, ".reg_a"}, 8'(reg_a), 8'(a));
    check({tag, ".reg_b"}, 8'(reg_b), 8'(b));
    check({tag, ".out_port"}, 8'(out_port), 8'(o));
    check({tag, ".pc"}, 8'(pc), 8'(p));
    check({tag, ".carry_flag"}, 8'(carry_flag), 8'(c));
    check({tag, ".out_strobe"}, 8'(out_strobe), 8'(s));
    check({tag, ".load_onehot"}, 8'(load_onehot), 8'(l));
  endtask

  initial begin
    // Reset overrides a pending write to A with carry_in high.
    reset = 1'b1; step = 1'b1; dest_en = 1'b1; dest_sel = 2'd0;
    result = 4'hF; carry_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'b0000);
    end

    // Walk all four destinations.
    reset = 1'b0; carry_in = 1'b0;
    dest_sel = 2'd0; result = 4'h3; tick();
    check_state("walk_a", 4'h3, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 4'b0001);
    dest_sel = 2'd1; result = 4'h5; tick();
    check_state("walk_b", 4'h3, 4'h5, 4'h0, 4'h2, 1'b0, 1'b0, 4'b0010);
    dest_sel = 2'd2; result = 4'h9; tick();
    check_state("walk_out", 4'h3, 4'h5, 4'h9, 4'h3, 1'b0, 1'b1, 4'b0100);
    dest_sel = 2'd3; result = 4'hC; tick();
    check_state("walk_pc", 4'h3, 4'h5, 4'h9, 4'hC, 1'b0, 1'b0, 4'b1000);

    // Jump to E, then idle across the wrap.
    result = 4'hE; tick();
    check_state("jump_e", 4'h3, 4'h5, 4'h9, 4'hE, 1'b0, 1'b0, 4'b1000);
    dest_en = 1'b0;
    tick(); check_state("wrap_f", 4'h3, 4'h5, 4'h9, 4'hF, 1'b0, 1'b0, 4'b0000);
    tick(); check_state("wrap_0", 4'h3, 4'h5, 4'h9, 4'h0, 1'b0, 1'b0, 4'b0000);
    tick(); check_state("wrap_1", 4'h3, 4'h5, 4'h9, 4'h1, 1'b0, 1'b0, 4'b0000);

    // Jump must replace the increment.
    dest_en = 1'b1; dest_sel = 2'd3; result = 4'h4; tick();
    check("jump_to_4", 8'(pc), 8'h04);
    result = 4'h2; tick();
    check("jump_not_inc", 8'(pc), 8'h02);
    dest_en = 1'b0; tick();
    check("inc_after_jump", 8'(pc), 8'h03);

    // Write OUT so the strobe is high going into the stall.
    dest_en = 1'b1; dest_sel = 2'd2; result = 4'h6; tick();
    check_state("pre_stall", 4'h3, 4'h5, 4'h6, 4'h4, 1'b0, 1'b1, 4'b0100);

    // Stall: write to B and carry_in=1 both ignored; pulses drop.
    step = 1'b0; dest_sel = 2'd1; result = 4'h7; carry_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state("stall", 4'h3, 4'h5, 4'h6, 4'h4, 1'b0, 1'b0, 4'b0000);
    end

    // Carry tracks with no write; unknown dest_sel is harmless when disabled.
    step = 1'b1; dest_en = 1'b0; dest_sel = 2'bxx; tick();
    check_state("carry_x", 4'h3, 4'h5, 4'h6, 4'h5, 1'b1, 1'b0, 4'b0000);

    // Reset on the same edge as an OUT write discards the write.
    reset = 1'b1; dest_en = 1'b1; dest_sel = 2'd2; result = 4'hA; tick();
    check_state("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'b0000);

    reset = 1'b0; dest_en = 1'b0; carry_in = 1'b0; tick();
    check_state("post_reset", 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
